// File: rtl/risc_pkg.sv
// risc_pkg: phase encodings, sequencer state encoding and default counter width
package risc_pkg;

    localparam int CNT_W_DEF = 16;

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        HALTED    = 2'd1,
        STEP_WAIT = 2'd2
    } seq_state_t;

endpackage

// File: rtl/phase_sequencer_sat_counter.sv
// sat_counter: enabled up-counter that sticks at all-ones, async active-low clear
module sat_counter
    import risc_pkg::*;
#(
    parameter int W = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count
);

    // Count enabled events, holding once every bit is set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (en && count != '1)
            count <= count + W'(1);
    end

endmodule

// File: rtl/phase_sequencer.sv
// phase_sequencer: 8-phase instruction sequencer with halt/go, stall and retire count.
// Define PHASE_SEQ_STEP_EN to compile in single-instruction step support.
module phase_sequencer
    import risc_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             halt,
    input  logic             go,
    input  logic             stall,
    input  logic             step_mode,
    input  logic             step_req,
    output logic [2:0]       phase,
    output logic             running,
    output logic             fetch_start,
    output logic             step_ack,
    output logic [CNT_W-1:0] instr_cnt
);

    seq_state_t state, state_d;
    logic [2:0] phase_d;
    logic       wrap, fetch_d, ack_d;

`ifndef PHASE_SEQ_STEP_EN
    logic unused_step;
    assign unused_step = step_mode | step_req;
`endif

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            phase       <= INST_ADDR;
            running     <= 1'b1;
            fetch_start <= 1'b0;
            step_ack    <= 1'b0;
        end else begin
            state       <= state_d;
            phase       <= phase_d;
            running     <= state_d == RUN;
            fetch_start <= fetch_d;
            step_ack    <= ack_d;
        end
    end

    // Next state and phase; a halt in OP_ADDR beats stall
    always_comb begin
        state_d = state;
        phase_d = phase;
        if (state == RUN) begin
            if (phase == OP_ADDR && halt) begin
                state_d = HALTED;
            end else if (!stall) begin
                phase_d = phase + 3'd1;
`ifdef PHASE_SEQ_STEP_EN
                if (phase == STORE && step_mode)
                    state_d = STEP_WAIT;
`endif
            end
        end else if (state == HALTED) begin
            if (go) begin
                state_d = RUN;
                phase_d = INST_ADDR;
            end
        end
`ifdef PHASE_SEQ_STEP_EN
        else if (step_req) begin
            state_d = RUN;
            phase_d = INST_FETCH;
        end
`endif
    end

    // Retire on wrap; fetch_start only on entry into phase 0, never while stalled there
    always_comb begin
        wrap    = state == RUN && !stall && phase == STORE;
        fetch_d = wrap || (state == HALTED && go);
`ifdef PHASE_SEQ_STEP_EN
        ack_d   = state == STEP_WAIT && step_req;
`else
        ack_d   = 1'b0;
`endif
    end

    sat_counter #(.W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (wrap),
        .count (instr_cnt)
    );

endmodule
